// File: rtl/router_pkg.sv
// Shared constants and types for the router output-link arbiters.
package router_pkg;

   localparam int DW             = 8;
   localparam int BYTES_PER_FLIT = 4;
   localparam int FLIT_W         = DW * BYTES_PER_FLIT;
   localparam int N_PORTS        = 4;
   localparam int SRC_W          = $clog2(N_PORTS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } arb_state_t;

   typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/router_flit_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after start,
// wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] grant,
   output logic         found
);

   logic [W-1:0] grant_s;
   logic         found_s;

   // Scan N candidates starting at start; the first hit wins.
   always_comb begin
      logic [W:0]   sum_v;
      logic [W-1:0] idx_v;
      grant_s = {W{1'b0}};
      found_s = 1'b0;
      sum_v   = {(W+1){1'b0}};
      idx_v   = {W{1'b0}};
      for (int k = 0; k < N; k++) begin
         sum_v = {1'b0, start} + (W+1)'(k);
         // explicit wrap so non-power-of-two N stays in range
         sum_v = (sum_v >= (W+1)'(N)) ? (sum_v - (W+1)'(N)) : sum_v;
         idx_v = sum_v[W-1:0];
         grant_s = (!found_s && req[idx_v]) ? idx_v : grant_s;
         found_s = found_s | req[idx_v];
      end
   end

   assign grant = grant_s;
   assign found = found_s;

endmodule

// File: rtl/router_flit_arbiter.sv
// Round-robin arbiter: grants one input FIFO, pops one flit's worth of bytes,
// and offers the assembled flit downstream on a valid/ready handshake.
module router_flit_arbiter #(
   parameter int N_IN           = router_pkg::N_PORTS,
   parameter int DW             = router_pkg::DW,
   parameter int BYTES_PER_FLIT = router_pkg::BYTES_PER_FLIT,
   parameter int SRC_W          = router_pkg::SRC_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_IN-1:0]              in_flit_avl,
   input  logic [N_IN*DW-1:0]           in_data,
   output logic [N_IN-1:0]              in_rd,
   output logic                         out_valid,
   output logic [DW*BYTES_PER_FLIT-1:0] out_flit,
   output logic [SRC_W-1:0]             out_src,
   input  logic                         out_ready,
   output logic                         busy
);
   import router_pkg::*;

   localparam int FW  = DW * BYTES_PER_FLIT;
   localparam int BCW = $clog2(BYTES_PER_FLIT);

   arb_state_t       state_r, state_n_s;
   logic [SRC_W-1:0] grant_r, grant_n_s;
   logic [SRC_W-1:0] rr_ptr_r, rr_ptr_n_s;
   logic [BCW-1:0]   byte_cnt_r, byte_cnt_n_s;
   logic [FW-1:0]    flit_r, flit_n_s;
   logic [SRC_W-1:0] next_ptr_s, start_s, pick_s;
   logic             found_s, last_s;
   logic [DW-1:0]    head_s;
   logic [N_IN-1:0]  rd_s;

   assign next_ptr_s = (grant_r == SRC_W'(N_IN-1)) ? {SRC_W{1'b0}} : (grant_r + SRC_W'(1));
   // at the handshake the search already uses the post-grant priority
   assign start_s    = (state_r == SEND) ? next_ptr_s : rr_ptr_r;
   assign last_s     = (byte_cnt_r == BCW'(BYTES_PER_FLIT-1));

   rr_pick #(.N(N_IN), .W(SRC_W)) u_pick (
      .req   (in_flit_avl),
      .start (start_s),
      .grant (pick_s),
      .found (found_s)
   );

   // Head-byte mux and one-hot read strobe for the granted FIFO.
   always_comb begin
      head_s = {DW{1'b0}};
      rd_s   = {N_IN{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
         head_s  = (grant_r == SRC_W'(i)) ? in_data[i*DW +: DW] : head_s;
         rd_s[i] = (state_r == READ) && (grant_r == SRC_W'(i));
      end
   end

   // Next-state, grant, pointer and flit assembly.
   always_comb begin
      state_n_s    = state_r;
      grant_n_s    = grant_r;
      rr_ptr_n_s   = rr_ptr_r;
      byte_cnt_n_s = byte_cnt_r;
      flit_n_s     = flit_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_n_s    = READ;
               grant_n_s    = pick_s;
               byte_cnt_n_s = {BCW{1'b0}};
            end else begin
               state_n_s    = IDLE;
            end
         end
         READ: begin
            for (int b = 0; b < BYTES_PER_FLIT; b++) begin
               flit_n_s[b*DW +: DW] = (byte_cnt_r == BCW'(b)) ? head_s : flit_r[b*DW +: DW];
            end
            if (last_s) begin
               state_n_s    = SEND;
               byte_cnt_n_s = {BCW{1'b0}};
            end else begin
               state_n_s    = READ;
               byte_cnt_n_s = byte_cnt_r + BCW'(1);
            end
         end
         SEND: begin
            if (out_ready) begin
               rr_ptr_n_s = next_ptr_s;
               if (found_s) begin
                  state_n_s    = READ;
                  grant_n_s    = pick_s;
                  byte_cnt_n_s = {BCW{1'b0}};
               end else begin
                  state_n_s    = IDLE;
               end
            end else begin
               state_n_s = SEND;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         grant_r    <= {SRC_W{1'b0}};
         rr_ptr_r   <= {SRC_W{1'b0}};
         byte_cnt_r <= {BCW{1'b0}};
         flit_r     <= {FW{1'b0}};
      end else begin
         state_r    <= state_n_s;
         grant_r    <= grant_n_s;
         rr_ptr_r   <= rr_ptr_n_s;
         byte_cnt_r <= byte_cnt_n_s;
         flit_r     <= flit_n_s;
      end
   end

   assign in_rd     = rd_s;
   assign out_valid = (state_r == SEND);
   assign busy      = (state_r != IDLE);
   assign out_flit  = flit_r;
   assign out_src   = grant_r;

endmodule

// File: tb/tb_router_flit_arbiter.sv
// Directed bench for router_flit_arbiter with a byte-FIFO model per input.
module tb_router_flit_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in_flit_avl = 4'b0000;
   logic [31:0] in_data;
   logic [3:0]  in_rd;
   logic        out_valid;
   logic [31:0] out_flit;
   logic [1:0]  out_src;
   logic        out_ready = 1'b0;
   logic        busy;

   bit [7:0] mem [4][64];
   int       rp [4];
   int       n_cmp = 0;
   int       n_mis = 0;
   int       rd_err = 0;

   always #5 clk = ~clk;

   router_flit_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .in_flit_avl (in_flit_avl),
      .in_data     (in_data),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_flit    (out_flit),
      .out_src     (out_src),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_head
      assign in_data[g*8 +: 8] = mem[g][rp[g]];
   end

   // FIFO model: a read strobe pops the head at the clock edge.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (in_rd[i]) rp[i] <= (rp[i] + 1) & 63;
      end
   end

   // Read strobe must be at most one-hot and only while reading.
   always @(negedge clk) begin
      if (!rst && (((in_rd & (in_rd - 4'd1)) != 4'd0) ||
                   ((in_rd != 4'd0) && (!busy || out_valid))))
         rd_err <= rd_err + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic put(input int f, input int off, input logic [31:0] w);
      for (int k = 0; k < 4; k++) mem[f][(rp[f] + off + k) & 63] = w[k*8 +: 8];
   endtask

   task automatic wait_valid(output int n);
      step();
      n = 1;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk("valid_seen", {63'd0, out_valid}, 64'd1);
   endtask

   int          n;
   int          s;
   logic [31:0] t2_flit [5] = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140, 32'h17161514};
   logic [1:0]  t2_src  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      // reset values
      do_reset();
      chk("rst_rd",    {60'd0, in_rd},     64'd0);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_flit",  {32'd0, out_flit},  64'd0);
      chk("rst_src",   {62'd0, out_src},   64'd0);
      chk("rst_busy",  {63'd0, busy},      64'd0);

      // single requester, FIFO1
      put(1, 0, 32'h44332211);
      out_ready   = 1'b1;
      in_flit_avl = 4'b0010;
      step();
      chk("t1_rd0",   {60'd0, in_rd}, 64'h2);
      chk("t1_busy",  {63'd0, busy},  64'd1);
      in_flit_avl = 4'b0000;
      for (int k = 1; k < 4; k++) begin
         step();
         chk("t1_rd", {60'd0, in_rd}, 64'h2);
      end
      step();
      chk("t1_valid", {63'd0, out_valid}, 64'd1);
      chk("t1_flit",  {32'd0, out_flit},  64'h44332211);
      chk("t1_src",   {62'd0, out_src},   64'd1);
      step();
      chk("t1_idle",  {63'd0, busy},      64'd0);

      // all four requesting, round-robin order and throughput
      do_reset();
      put(0, 0, 32'h13121110); put(0, 4, 32'h17161514);
      put(1, 0, 32'h23222120); put(1, 4, 32'h27262524);
      put(2, 0, 32'h33323130); put(2, 4, 32'h37363534);
      put(3, 0, 32'h43424140); put(3, 4, 32'h47464544);
      in_flit_avl = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_valid(n);
         chk("t2_lat",  64'(n),             64'd5);
         chk("t2_src",  {62'd0, out_src},   {62'd0, t2_src[f]});
         chk("t2_flit", {32'd0, out_flit},  {32'd0, t2_flit[f]});
         if (f == 4) in_flit_avl = 4'b0000;
      end
      step();
      chk("t2_idle", {63'd0, busy}, 64'd0);

      // backpressure holds SEND
      do_reset();
      put(2, 0, 32'hA3A2A1A0);
      put(2, 4, 32'hA7A6A5A4);
      out_ready   = 1'b0;
      in_flit_avl = 4'b0100;
      wait_valid(n);
      chk("t3_flit", {32'd0, out_flit}, 64'hA3A2A1A0);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t3_hold", {27'd0, out_valid, in_rd, out_flit}, {27'd0, 1'b1, 4'b0000, 32'hA3A2A1A0});
      end
      out_ready = 1'b1;
      step();
      chk("t3_next_rd",    {60'd0, in_rd},     64'h4);
      chk("t3_next_valid", {63'd0, out_valid}, 64'd0);

      // wrap from pointer 3 to FIFO1, then skip to FIFO3
      put(1, 0, 32'hB3B2B1B0);
      in_flit_avl = 4'b0010;
      wait_valid(n);
      chk("t3_flit2", {32'd0, out_flit}, 64'hA7A6A5A4);
      chk("t3_src2",  {62'd0, out_src},  64'd2);
      wait_valid(n);
      chk("t4_wrap_src",  {62'd0, out_src},  64'd1);
      chk("t4_wrap_flit", {32'd0, out_flit}, 64'hB3B2B1B0);
      put(3, 0, 32'hC3C2C1C0);
      in_flit_avl = 4'b1010;
      wait_valid(n);
      chk("t4_skip_src",  {62'd0, out_src},  64'd3);
      chk("t4_skip_flit", {32'd0, out_flit}, 64'hC3C2C1C0);
      in_flit_avl = 4'b0000;
      step();
      chk("t4_idle", {63'd0, busy}, 64'd0);

      // avl drops mid-READ: all bytes still popped
      put(2, 0, 32'hD3D2D1D0);
      s = rp[2];
      in_flit_avl = 4'b0100;
      step();
      step();
      step();
      in_flit_avl = 4'b0000;
      step();
      step();
      chk("t5_valid", {63'd0, out_valid}, 64'd1);
      chk("t5_flit",  {32'd0, out_flit},  64'hD3D2D1D0);
      chk("t5_src",   {62'd0, out_src},   64'd2);
      chk("t5_pops",  64'((rp[2] - s) & 63), 64'd4);
      step();
      chk("t5_idle",  {63'd0, busy}, 64'd0);

      // reset in the 3rd READ cycle, then priority restarts at FIFO0
      put(1, 0, 32'hE3E2E1E0);
      in_flit_avl = 4'b0010;
      step();
      step();
      step();
      rst = 1'b1;
      in_flit_avl = 4'b0000;
      step();
      chk("t6_rd",    {60'd0, in_rd},     64'd0);
      chk("t6_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_busy",  {63'd0, busy},      64'd0);
      chk("t6_flit",  {32'd0, out_flit},  64'd0);
      chk("t6_src",   {62'd0, out_src},   64'd0);
      rst = 1'b0;
      put(0, 0, 32'hF3F2F1F0);
      put(3, 0, 32'h93929190);
      in_flit_avl = 4'b1101;
      wait_valid(n);
      chk("t6_lat",  64'(n),            64'd5);
      chk("t6_src0", {62'd0, out_src},  64'd0);
      chk("t6_flit0",{32'd0, out_flit}, 64'hF3F2F1F0);
      in_flit_avl = 4'b0000;
      step();

      chk("rd_onehot", 64'(rd_err), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
